sprite_blit_engine: RTL and testbench

Parametrised successor to the fixed car/background drawer. Renders a full-screen background and a lane-positioned sprite to the VGA adapter pixel interface. Adds a start/done handshake, mode select, erase-and-redraw of the previous sprite rectangle, sprite transparency, and a latency-aligned pipeline for synchronous ROMs. Sits between the game controller, the background and sprite ROMs, and the VGA adapter.

---
 rtl/sprite_blit_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_sprite_blit_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blit_engine.sv
// rtl/sprite_blit_engine.sv - background/sprite blitter with erase-and-redraw
// Issues one ROM address per cycle and re-aligns coordinates with the ROM latency.
module sprite_blit_engine #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int SPR_W       = 10,
    parameter int SPR_H       = 20,
    parameter int NUM_LANES   = 3,
    parameter int LANE_X0     = 40,
    parameter int LANE_PITCH  = 40,
    parameter int SPR_Y       = 90,
    parameter int CW          = 3,
    parameter int ROM_LAT     = 1,
    parameter int TRANSPARENT = 0,
    localparam int BG_AW      = $clog2(SCREEN_W * SCREEN_H),
    localparam int SPR_AW     = $clog2(SPR_W * SPR_H),
    localparam int LW         = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1
) (
    input  logic              iClock,
    input  logic              iResetn,
    input  logic              iStart,
    input  logic [1:0]        iMode,
    input  logic [LW-1:0]     iLane,
    output logic [BG_AW-1:0]  oBgAddr,
    input  logic [CW-1:0]     iBgColour,
    output logic [SPR_AW-1:0] oSprAddr,
    input  logic [CW-1:0]     iSprColour,
    output logic [8:0]        oX,
    output logic [7:0]        oY,
    output logic [CW-1:0]     oColour,
    output logic              oPlot,
    output logic              oBusy,
    output logic              oDone
);

    if ((LANE_X0 + (NUM_LANES - 1) * LANE_PITCH + SPR_W > SCREEN_W) ||
        (SPR_Y + SPR_H > SCREEN_H) || (ROM_LAT < 1)) begin : g_bad_params
        $error("sprite_blit_engine: sprite does not fit on screen or ROM_LAT < 1");
    end

    localparam logic [8:0] RESET_X = 9'(LANE_X0 + (NUM_LANES / 2) * LANE_PITCH);
    localparam logic [1:0] PH_FULL = 2'd0;
    localparam logic [1:0] PH_RECT = 2'd1;
    localparam logic [1:0] PH_SPR  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_BG_FULL, S_BG_RECT, S_SPRITE, S_DRAIN, S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic [8:0]        r_col;
    logic [7:0]        r_row;
    logic [8:0]        r_new_x;
    logic [8:0]        r_prev_x;
    logic [7:0]        r_drain;

    logic [31:0]       w_lane_sel;
    logic [8:0]        w_acc_x;
    logic [8:0]        w_cur_new_x;
    logic [8:0]        w_last_col;
    logic              w_wrap;
    logic [8:0]        w_adv_col;
    logic [7:0]        w_adv_row;
    logic              w_full_last;
    logic              w_spr_last;
    logic              w_issue;
    logic [1:0]        w_ph;
    logic [8:0]        w_col;
    logic [7:0]        w_row;
    logic [8:0]        w_base_x;
    logic [8:0]        w_px;
    logic [7:0]        w_py;
    logic [BG_AW-1:0]  w_bg_addr;
    logic [SPR_AW-1:0] w_spr_addr;

    // Out-of-range lanes fall back to the middle lane.
    assign w_lane_sel  = (32'(iLane) >= NUM_LANES) ? 32'(NUM_LANES / 2) : 32'(iLane);
    assign w_acc_x     = 9'(LANE_X0 + w_lane_sel * LANE_PITCH);
    assign w_cur_new_x = (r_state == S_IDLE) ? w_acc_x : r_new_x;

    assign w_last_col  = (r_state == S_BG_FULL) ? 9'(SCREEN_W - 1) : 9'(SPR_W - 1);
    assign w_wrap      = (r_col == w_last_col);
    assign w_adv_col   = w_wrap ? 9'd0 : r_col + 9'd1;
    assign w_adv_row   = w_wrap ? r_row + 8'd1 : r_row;
    assign w_full_last = (r_col == 9'(SCREEN_W - 1)) && (r_row == 8'(SCREEN_H - 1));
    assign w_spr_last  = (r_col == 9'(SPR_W - 1)) && (r_row == 8'(SPR_H - 1));

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // w_issue/w_ph/w_col/w_row describe the pixel whose address goes out next edge;
    // phase changes issue pixel 0 of the new phase in the same step, so no bubble.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_ph         = PH_FULL;
        w_col        = w_adv_col;
        w_row        = w_adv_row;
        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_issue = 1'b1;
                    w_col   = 9'd0;
                    w_row   = 8'd0;
                    case (iMode)
                        2'b01:   begin w_state_next = S_SPRITE;  w_ph = PH_SPR;  end
                        2'b10:   begin w_state_next = S_BG_RECT; w_ph = PH_RECT; end
                        default: begin w_state_next = S_BG_FULL; w_ph = PH_FULL; end
                    endcase
                end
            end
            S_BG_FULL: begin
                w_issue = 1'b1;
                if (w_full_last) begin
                    w_state_next = S_SPRITE;
                    w_ph  = PH_SPR;
                    w_col = 9'd0;
                    w_row = 8'd0;
                end
            end
            S_BG_RECT: begin
                w_issue = 1'b1;
                w_ph    = PH_RECT;
                if (w_spr_last) begin
                    w_state_next = S_SPRITE;
                    w_ph  = PH_SPR;
                    w_col = 9'd0;
                    w_row = 8'd0;
                end
            end
            S_SPRITE: begin
                if (w_spr_last) begin
                    w_state_next = S_DRAIN;
                end else begin
                    w_issue = 1'b1;
                    w_ph    = PH_SPR;
                end
            end
            S_DRAIN: begin
                if (r_drain == 8'(ROM_LAT - 1)) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_base_x   = (w_ph == PH_SPR) ? w_cur_new_x : (w_ph == PH_RECT) ? r_prev_x : 9'd0;
    assign w_px       = w_base_x + w_col;
    assign w_py       = (w_ph == PH_FULL) ? w_row : 8'(SPR_Y) + w_row;
    assign w_bg_addr  = BG_AW'(w_py) * BG_AW'(SCREEN_W) + BG_AW'(w_px);
    assign w_spr_addr = SPR_AW'(w_row) * SPR_AW'(SPR_W) + SPR_AW'(w_col);

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_col    <= 9'd0;
            r_row    <= 8'd0;
            r_new_x  <= RESET_X;
            r_prev_x <= RESET_X;
            r_drain  <= 8'd0;
            oBgAddr  <= '0;
            oSprAddr <= '0;
        end else begin
            if (w_issue) begin
                r_col <= w_col;
                r_row <= w_row;
                if (w_ph == PH_SPR) oSprAddr <= w_spr_addr;
                else                oBgAddr  <= w_bg_addr;
            end
            if (r_state == S_IDLE && iStart) r_new_x <= w_acc_x;
            r_drain <= (r_state == S_DRAIN) ? r_drain + 8'd1 : 8'd0;
            if (r_state == S_DONE) r_prev_x <= r_new_x;
        end
    end

    // Stage 0 travels with the address; stage ROM_LAT lines up with ROM data.
    logic       r_dv   [0:ROM_LAT];
    logic       r_dspr [0:ROM_LAT];
    logic [8:0] r_dx   [0:ROM_LAT];
    logic [7:0] r_dy   [0:ROM_LAT];

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_dv[i]   <= 1'b0;
                r_dspr[i] <= 1'b0;
                r_dx[i]   <= 9'd0;
                r_dy[i]   <= 8'd0;
            end
        end else begin
            r_dv[0]   <= w_issue;
            r_dspr[0] <= (w_ph == PH_SPR);
            r_dx[0]   <= w_px;
            r_dy[0]   <= w_py;
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_dv[i]   <= r_dv[i-1];
                r_dspr[i] <= r_dspr[i-1];
                r_dx[i]   <= r_dx[i-1];
                r_dy[i]   <= r_dy[i-1];
            end
        end
    end

    logic          w_out_spr;
    logic [CW-1:0] w_rom;

    assign w_out_spr = r_dspr[ROM_LAT];
    assign w_rom     = w_out_spr ? iSprColour : iBgColour;
    assign oX        = r_dx[ROM_LAT];
    assign oY        = r_dy[ROM_LAT];
    assign oColour   = r_dv[ROM_LAT] ? w_rom : '0;
    assign oPlot     = r_dv[ROM_LAT] && (!w_out_spr || (w_rom != CW'(TRANSPARENT)));
    assign oBusy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign oDone     = (r_state == S_DONE);

endmodule

// File: tb/tb_sprite_blit_engine.sv
// tb/tb_sprite_blit_engine.sv - scoreboard bench for sprite_blit_engine
module tb_sprite_blit_engine;

    logic        clk = 1'b0;
    logic        iResetn = 1'b0;
    logic        iStart = 1'b0;
    logic [1:0]  iMode = 2'd0;
    logic [1:0]  iLane = 2'd0;

    logic [14:0] oBgAddr1, oBgAddr3;
    logic [7:0]  oSprAddr1, oSprAddr3;
    logic [2:0]  bgc1, sprc1;
    logic [2:0]  b3 [0:2];
    logic [2:0]  s3 [0:2];
    logic [8:0]  oX1, oX3;
    logic [7:0]  oY1, oY3;
    logic [2:0]  oColour1, oColour3;
    logic        oPlot1, oPlot3, oBusy1, oBusy3, oDone1, oDone3;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int d1_cnt, d3_cnt, d1_cyc, d3_cyc, plot1;
    int m_prev = 80;

    typedef struct {
        int cyc;
        int x;
        int y;
        int col;
        bit plot;
    } pix_t;
    pix_t q1[$];
    pix_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_blit_engine #(.ROM_LAT(1)) dut1 (
        .iClock(clk), .iResetn(iResetn), .iStart(iStart), .iMode(iMode), .iLane(iLane),
        .oBgAddr(oBgAddr1), .iBgColour(bgc1), .oSprAddr(oSprAddr1), .iSprColour(sprc1),
        .oX(oX1), .oY(oY1), .oColour(oColour1), .oPlot(oPlot1), .oBusy(oBusy1), .oDone(oDone1)
    );

    sprite_blit_engine #(.ROM_LAT(3)) dut3 (
        .iClock(clk), .iResetn(iResetn), .iStart(iStart), .iMode(iMode), .iLane(iLane),
        .oBgAddr(oBgAddr3), .iBgColour(b3[2]), .oSprAddr(oSprAddr3), .iSprColour(s3[2]),
        .oX(oX3), .oY(oY3), .oColour(oColour3), .oPlot(oPlot3), .oBusy(oBusy3), .oDone(oDone3)
    );

    function automatic logic [2:0] bgf(input int a);
        return 3'(a ^ (a >> 3));
    endfunction

    // Column 0 of the sprite is transparent.
    function automatic logic [2:0] sprf(input int a);
        return (a % 10 == 0) ? 3'd0 : 3'((a % 7) + 1);
    endfunction

    always @(posedge clk) begin
        bgc1  <= bgf(int'(oBgAddr1));
        sprc1 <= sprf(int'(oSprAddr1));
        b3[0] <= bgf(int'(oBgAddr3));
        s3[0] <= sprf(int'(oSprAddr3));
        for (int i = 1; i < 3; i++) begin
            b3[i] <= b3[i-1];
            s3[i] <= s3[i-1];
        end
    end

    task automatic expect_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            pix_t e;
            e = q1.pop_front();
            expect_eq("x_lat1", int'(oX1), e.x);
            expect_eq("y_lat1", int'(oY1), e.y);
            expect_eq("plot_lat1", int'(oPlot1), int'(e.plot));
            if (e.plot) expect_eq("colour_lat1", int'(oColour1), e.col);
        end else if (oPlot1) begin
            expect_eq("stray_plot_lat1", 1, 0);
        end
        if (oDone1) begin d1_cnt++; d1_cyc = cyc; end
        if (oPlot1) plot1++;
    end

    always @(negedge clk) begin
        if (q3.size() > 0 && q3[0].cyc == cyc) begin
            pix_t e;
            e = q3.pop_front();
            expect_eq("x_lat3", int'(oX3), e.x);
            expect_eq("y_lat3", int'(oY3), e.y);
            expect_eq("plot_lat3", int'(oPlot3), int'(e.plot));
            if (e.plot) expect_eq("colour_lat3", int'(oColour3), e.col);
        end else if (oPlot3) begin
            expect_eq("stray_plot_lat3", 1, 0);
        end
        if (oDone3) begin d3_cnt++; d3_cyc = cyc; end
    end

    task automatic push_pix(input int i, input int k, input int x, input int y,
                            input int col, input bit p);
        q1.push_back('{k + 2 + i, x, y, col, p});
        q3.push_back('{k + 4 + i, x, y, col, p});
    endtask

    task automatic push_expected(input int mode, input int lx, input int k);
        int i = 0;
        if (mode == 0) begin
            for (int y = 0; y < 120; y++)
                for (int x = 0; x < 160; x++) begin
                    push_pix(i, k, x, y, int'(bgf(y * 160 + x)), 1'b1);
                    i++;
                end
        end else if (mode == 2) begin
            for (int r = 0; r < 20; r++)
                for (int c = 0; c < 10; c++) begin
                    push_pix(i, k, m_prev + c, 90 + r, int'(bgf((90 + r) * 160 + m_prev + c)), 1'b1);
                    i++;
                end
        end
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) begin
                int s;
                s = int'(sprf(r * 10 + c));
                push_pix(i, k, lx + c, 90 + r, s, s != 0);
                i++;
            end
    endtask

    // mode: 0 FULL, 1 SPRITE, 2 ERASE; noise pulses iStart while busy.
    task automatic run(input int mode, input int lane, input bit noise, input bit mid_reset);
        int n, k, lx, sel;
        sel = (lane >= 3) ? 1 : lane;
        lx  = 40 + sel * 40;
        n   = (mode == 1) ? 200 : (mode == 2) ? 400 : 19400;
        @(negedge clk);
        k = cyc;
        d1_cnt = 0; d3_cnt = 0; plot1 = 0;
        iMode = 2'(mode); iLane = 2'(lane); iStart = 1'b1;
        push_expected(mode, lx, k);
        @(negedge clk);
        iStart = 1'b0;
        expect_eq("busy_after_accept", int'(oBusy1), 1);
        if (mode == 2) expect_eq("erase_first_addr", int'(oBgAddr1), 90 * 160 + m_prev);
        if (mode == 0) expect_eq("full_first_addr", int'(oBgAddr1), 0);
        if (mid_reset) begin
            repeat (50) @(negedge clk);
            #1 iResetn = 1'b0;
            #1;
            expect_eq("rst_plot1", int'(oPlot1), 0);
            expect_eq("rst_busy1", int'(oBusy1), 0);
            expect_eq("rst_plot3", int'(oPlot3), 0);
            expect_eq("rst_busy3", int'(oBusy3), 0);
            q1.delete();
            q3.delete();
            repeat (3) @(negedge clk);
            expect_eq("rst_no_done", d1_cnt + d3_cnt, 0);
            iResetn = 1'b1;
            m_prev = 80;
            return;
        end
        for (int t = 0; t < n + 20 && !(d1_cnt > 0 && d3_cnt > 0); t++) begin
            @(negedge clk);
            iStart = noise && (t % 37 == 5) && (t < n - 10);
            iMode  = noise ? 2'(t % 3) : iMode;
        end
        iStart = 1'b0;
        repeat (3) @(negedge clk);
        expect_eq("done_count_lat1", d1_cnt, 1);
        expect_eq("done_count_lat3", d3_cnt, 1);
        expect_eq("done_cycle_lat1", d1_cyc, k + n + 2);
        expect_eq("done_cycle_lat3", d3_cyc, k + n + 4);
        expect_eq("idle_busy", int'(oBusy1), 0);
        expect_eq("queue_left_lat1", q1.size(), 0);
        expect_eq("queue_left_lat3", q3.size(), 0);
        if (mode == 0) expect_eq("full_plot_count", plot1, 19380);
        q1.delete();
        q3.delete();
        m_prev = lx;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        expect_eq("reset_x", int'(oX1), 0);
        expect_eq("reset_y", int'(oY1), 0);
        expect_eq("reset_colour", int'(oColour1), 0);
        expect_eq("reset_plot", int'(oPlot1), 0);
        expect_eq("reset_busy", int'(oBusy1), 0);
        expect_eq("reset_done", int'(oDone1), 0);
        expect_eq("reset_bgaddr", int'(oBgAddr1), 0);
        expect_eq("reset_spraddr", int'(oSprAddr1), 0);
        expect_eq("reset_busy_lat3", int'(oBusy3), 0);
        iResetn = 1'b1;
        repeat (2) @(negedge clk);

        run(2, 0, 1'b0, 1'b0);   // erase restores prev_x 80, sprite to lane 0
        run(0, 0, 1'b0, 1'b0);   // full frame plus lane-0 sprite
        run(2, 2, 1'b0, 1'b0);   // erase lane 0 rect, draw lane 2
        run(1, 3, 1'b1, 1'b0);   // invalid lane, ignored restarts
        run(1, 1, 1'b0, 1'b1);   // reset mid-sprite
        repeat (2) @(negedge clk);
        run(2, 0, 1'b0, 1'b0);   // after reset prev_x is 80 again

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
